// File: rtl/pulse_gen_pkg.sv
// Purpose: shared types and default sizes for the multi-channel pulse generator.
// Contents:
//   DEF_N_CH  - default number of pulse channels
//   DEF_CNT_W - default width of period, high-time and burst counters
//   state_t   - controller FSM states (IDLE, RUN, DONE)
package pulse_gen_pkg;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_gen_ch.sv
// Purpose: one pulse channel. Holds the shadow copy of its high time and
// enable, compares the shared phase against the high time, and registers the
// gated source level onto the output.
// Ports:
//   i_clk, i_rst - clock and synchronous active-high reset
//   i_load       - capture i_high_cnt / i_en into the shadow registers
//   i_run        - controller is in RUN; output is forced low otherwise
//   i_phase      - shared phase counter (0..period-1)
//   i_high_cnt   - requested high time in cycles
//   i_en         - requested channel enable
//   i_src        - level source gated onto the output
//   o_pulse      - registered gated pulse
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_phase,
  input  logic [CNT_W-1:0] i_high_cnt,
  input  logic             i_en,
  input  logic             i_src,
  output logic             o_pulse
);

  logic [CNT_W-1:0] r_high;
  logic             r_en;
  logic             r_pulse;
  logic             w_gate;

  // The gate uses only the shadow copy, so a new high time set mid-period
  // cannot disturb the period already in progress. A high time of zero
  // never opens the gate; one at or above the period keeps it open.
  assign w_gate = r_en && (i_phase < r_high);

  // Shadow registers reload only when the controller says so (run start or
  // period wrap). The output register adds the single cycle of latency
  // between the phase value and the visible pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_high  <= '0;
      r_en    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      if (i_load) begin
        r_high <= i_high_cnt;
        r_en   <= i_en;
      end
      r_pulse <= i_run & w_gate & i_src;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/pulse_gen_multi.sv
// Purpose: multi-channel pulse generator with a shared period counter,
// continuous or burst operation and per-channel duty.
// Ports:
//   wb_clk_i, wb_rst_i - clock and synchronous active-high reset
//   start_i, stop_i    - begin generation / end at next period boundary
//   mode_i             - 0 continuous, 1 burst
//   period_i           - period length in cycles
//   burst_len_i        - number of periods in burst mode
//   high_cnt_i         - per-channel high time, channel k at [k*CNT_W +: CNT_W]
//   ch_en_i, src_i     - per-channel enable and level source
//   pulse_o            - registered gated pulse outputs
//   busy_o, done_o     - in RUN / one-cycle completion pulse
//   cfg_err_o          - one-cycle pulse when a start is rejected
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  mode_i,
  input  logic [CNT_W-1:0]      period_i,
  input  logic [CNT_W-1:0]      burst_len_i,
  input  logic [N_CH*CNT_W-1:0] high_cnt_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [N_CH-1:0]       src_i,
  output logic [N_CH-1:0]       pulse_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_burst_len;
  logic             r_mode;
  logic             r_stop_pend;
  logic             r_cfg_err;

  logic w_cfg_ok;
  logic w_wrap;
  logic w_stop_seen;
  logic w_burst_end;
  logic w_accept;
  logic w_reject;
  logic w_run;
  logic w_load;

  assign w_cfg_ok    = (period_i != '0) && !(mode_i && (burst_len_i == '0));
  assign w_wrap      = (r_phase == (r_period - ONE));
  assign w_stop_seen = r_stop_pend | stop_i;
  assign w_burst_end = r_mode && (r_burst_cnt == (r_burst_len - ONE));
  assign w_run       = (r_state == ST_RUN);
  assign w_load      = w_accept | (w_run & w_wrap);

  // Next-state logic. A start together with stop is treated as no request
  // at all, so it neither starts a run nor flags a config error. Leaving RUN
  // only ever happens on a wrap, which guarantees whole periods.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          if (w_cfg_ok) begin
            w_accept     = 1'b1;
            w_next_state = ST_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_wrap && (w_stop_seen || w_burst_end)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops straight to IDLE so a run aborted by reset
  // never passes through DONE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Run datapath: period/mode/burst length are frozen at run start, the
  // phase counter wraps every period, and a stop request seen mid-period is
  // remembered until the wrap that honours it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_phase     <= '0;
      r_burst_cnt <= '0;
      r_period    <= '0;
      r_burst_len <= '0;
      r_mode      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      if (w_accept) begin
        r_period    <= period_i;
        r_burst_len <= burst_len_i;
        r_mode      <= mode_i;
        r_phase     <= '0;
        r_burst_cnt <= '0;
        r_stop_pend <= 1'b0;
      end else if (w_run) begin
        if (w_wrap) begin
          r_phase     <= '0;
          r_burst_cnt <= r_burst_cnt + ONE;
          r_stop_pend <= 1'b0;
        end else begin
          r_phase <= r_phase + ONE;
          if (stop_i) begin
            r_stop_pend <= 1'b1;
          end
        end
      end else begin
        r_phase     <= '0;
        r_stop_pend <= 1'b0;
      end
    end
  end

  // One channel instance per output; they share the phase counter and the
  // load strobe so all duty updates line up on the same period boundary.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pulse_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_load     (w_load),
      .i_run      (w_run),
      .i_phase    (r_phase),
      .i_high_cnt (high_cnt_i[k*CNT_W +: CNT_W]),
      .i_en       (ch_en_i[k]),
      .i_src      (src_i[k]),
      .o_pulse    (pulse_o[k])
    );
  end

  assign busy_o    = w_run;
  assign done_o    = (r_state == ST_DONE);
  assign cfg_err_o = r_cfg_err;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Purpose: self-checking bench for pulse_gen_multi. A behavioural model
// tracks each run as "cycles elapsed since run start" and derives phase and
// completed periods arithmetically; every cycle all outputs are compared.
module tb_pulse_gen_multi;

  localparam int N_CH  = 2;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [CNT_W-1:0]      period;
  logic [CNT_W-1:0]      burstLen;
  logic [N_CH*CNT_W-1:0] highCnt;
  logic [N_CH-1:0]       chEn;
  logic [N_CH-1:0]       src;
  logic [N_CH-1:0]       pulse;
  logic                  busy;
  logic                  done;
  logic                  cfgErr;

  int totalChecks = 0;
  int badChecks   = 0;

  // model state: 0 idle, 1 run, 2 done
  int  mState    = 0;
  int  mElapsed  = 0;
  int  mPeriod   = 0;
  int  mBurst    = 0;
  bit  mMode     = 1'b0;
  int  mHigh [N_CH];
  bit  mEn   [N_CH];
  bit  mStopPend = 1'b0;

  logic [N_CH-1:0] expPulse = '0;
  logic            expBusy  = 1'b0;
  logic            expDone  = 1'b0;
  logic            expErr   = 1'b0;

  pulse_gen_multi #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .stop_i      (stop),
    .mode_i      (mode),
    .period_i    (period),
    .burst_len_i (burstLen),
    .high_cnt_i  (highCnt),
    .ch_en_i     (chEn),
    .src_i       (src),
    .pulse_o     (pulse),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_err_o   (cfgErr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Behavioural reference: given the inputs about to be sampled, work out
  // what the outputs must look like after the coming clock edge.
  task automatic modelStep();
    logic [N_CH-1:0] nextPulse;
    bit              nextErr;
    int              ph;
    int              completed;
    bit              pend;
    nextPulse = '0;
    nextErr   = 1'b0;
    if (rst) begin
      mState    = 0;
      mStopPend = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        mHigh[k] = 0;
        mEn[k]   = 1'b0;
      end
    end else begin
      case (mState)
        0: begin
          if (start && !stop) begin
            if (period == 0 || (mode && burstLen == 0)) begin
              nextErr = 1'b1;
            end else begin
              mState    = 1;
              mElapsed  = 0;
              mPeriod   = int'(period);
              mBurst    = int'(burstLen);
              mMode     = mode;
              mStopPend = 1'b0;
              for (int k = 0; k < N_CH; k++) begin
                mHigh[k] = int'(highCnt[k*CNT_W +: CNT_W]);
                mEn[k]   = chEn[k];
              end
            end
          end
        end
        1: begin
          ph   = mElapsed % mPeriod;
          pend = mStopPend | stop;
          for (int k = 0; k < N_CH; k++) begin
            nextPulse[k] = src[k] & mEn[k] & (ph < mHigh[k]);
          end
          if (ph == mPeriod - 1) begin
            completed = mElapsed / mPeriod + 1;
            if (pend || (mMode && completed == mBurst)) begin
              mState = 2;
            end
            mStopPend = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
              mHigh[k] = int'(highCnt[k*CNT_W +: CNT_W]);
              mEn[k]   = chEn[k];
            end
          end else begin
            mStopPend = pend;
          end
          mElapsed++;
        end
        default: begin
          mState = 0;
        end
      endcase
    end
    expPulse = nextPulse;
    expErr   = nextErr;
    expBusy  = (mState == 1);
    expDone  = (mState == 2);
  endtask

  // One clock cycle with the currently driven inputs, then compare all
  // outputs half a cycle after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("pulse",   32'(pulse),  32'(expPulse));
    checkOutput("busy",    32'(busy),   32'(expBusy));
    checkOutput("done",    32'(done),   32'(expDone));
    checkOutput("cfg_err", 32'(cfgErr), 32'(expErr));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  function automatic logic [N_CH*CNT_W-1:0] packHigh(input int h0, input int h1);
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    v[0 +: CNT_W]     = CNT_W'(h0);
    v[CNT_W +: CNT_W] = CNT_W'(h1);
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    period = '0; burstLen = '0; highCnt = '0; chEn = '0; src = '0;
    @(negedge clk);
    runCycles(2);
    rst = 1'b0;
    runCycles(2);

    $display("[TB] continuous period=10 high={3,7}");
    period = 10; highCnt = packHigh(3, 7); chEn = 2'b11; src = 2'b11; mode = 1'b0;
    pulseStart();
    runCycles(30);
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    runCycles(12);

    $display("[TB] burst period=4 len=3 high=2");
    mode = 1'b1; period = 4; burstLen = 3; highCnt = packHigh(2, 2);
    pulseStart();
    runCycles(16);

    $display("[TB] rejected and suppressed starts");
    period = 0; mode = 1'b0;
    pulseStart();
    runCycles(2);
    period = 6; mode = 1'b1; burstLen = 0;
    pulseStart();
    runCycles(2);
    burstLen = 2; start = 1'b1; stop = 1'b1;
    applyStimulus();
    start = 1'b0; stop = 1'b0;
    runCycles(2);

    $display("[TB] stop at phase 2, duty change mid-period");
    mode = 1'b0; period = 8; highCnt = packHigh(2, 5);
    pulseStart();
    runCycles(2);
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    highCnt = packHigh(6, 1);
    runCycles(10);
    pulseStart();
    runCycles(3);
    highCnt = packHigh(1, 7);
    runCycles(12);
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    runCycles(10);

    $display("[TB] edge duties period=5");
    period = 5; highCnt = packHigh(0, 5);
    pulseStart();
    runCycles(10);
    highCnt = packHigh(9, 5); chEn = 2'b01;
    runCycles(10);
    chEn = 2'b11; src = 2'b01;
    runCycles(10);
    src = 2'b11; stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    runCycles(7);

    $display("[TB] reset during burst");
    mode = 1'b1; period = 6; burstLen = 4; highCnt = packHigh(3, 4);
    pulseStart();
    runCycles(3);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    runCycles(3);
    burstLen = 2;
    pulseStart();
    runCycles(15);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      mode     = $urandom_range(0, 1);
      period   = CNT_W'($urandom_range(0, 12));
      burstLen = CNT_W'($urandom_range(0, 5));
      highCnt  = packHigh($urandom_range(0, 14), $urandom_range(0, 14));
      chEn     = N_CH'($urandom_range(0, 3));
      src      = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 3)) : 2'b11;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 Parameter N_CH, default 2, number of independent pulse channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of period, high-time and burst counters.
REQ-003 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  single-cycle request to begin generation.
REQ-006 stop_i  input  1  request to end generation at the next period boundary.
REQ-007 mode_i  input  1  0 = continuous, 1 = burst.
REQ-008 period_i  input  CNT_W  period length in clock cycles.
REQ-009 burst_len_i  input  CNT_W  number of periods in burst mode.
REQ-010 high_cnt_i  input  N_CH*CNT_W  per-channel high time in cycles; channel k in bits [k*CNT_W +: CNT_W].
REQ-011 ch_en_i  input  N_CH  per-channel enable.
REQ-012 src_i  input  N_CH  per-channel level source gated onto the output (e.g. level-shifter outputs).
REQ-013 pulse_o  output  N_CH  registered gated pulse outputs.
REQ-014 busy_o  output  1  high while in RUN.
REQ-015 done_o  output  1  single-cycle pulse on completion.
REQ-016 cfg_err_o  output  1  single-cycle pulse when a start is rejected.

Function
REQ-017 FSM states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 IDLE->RUN on start_i=1, stop_i=0, valid config; period_i, burst_len_i, mode_i, high_cnt_i and ch_en_i are latched into shadow registers on that edge.
REQ-019 Invalid config is period_i=0, or mode_i=1 with burst_len_i=0; start is then ignored and cfg_err_o pulses the next cycle.
REQ-020 start_i and stop_i both high in IDLE: stop wins, no start, no cfg_err_o.
REQ-021 In RUN, phase counter counts 0..period-1 and wraps to 0; the first RUN cycle has phase 0.
REQ-022 At each wrap (phase = period-1), high_cnt_i and ch_en_i are re-latched, so duty changes apply only at period boundaries; period and mode stay fixed for the whole run.
REQ-023 Channel k gate = ch_en(k) and (phase < high_cnt(k)); high_cnt=0 gives a constant low; high_cnt>=period gives a constant high.
REQ-024 pulse_o(k) is registered src_i(k) AND gate(k): one cycle of latency from phase to output; 0 outside RUN.
REQ-025 Burst mode: period counter increments at each wrap; on the wrap completing period burst_len -> DONE.
REQ-026 stop_i seen in RUN is held pending; at the next wrap -> DONE. The current period is never truncated.
REQ-027 Continuous mode runs until stop is honoured.
REQ-028 start_i in RUN or DONE is ignored and does not raise cfg_err_o.
REQ-029 done_o is high for the DONE cycle; busy_o = (state == RUN).
REQ-030 All counters are CNT_W bits and compare unsigned; no overflow is possible since phase < period <= 2^CNT_W-1.

Reset
REQ-031 On wb_rst_i: state IDLE; phase, burst count, stop-pending and shadow registers 0; pulse_o, busy_o, done_o, cfg_err_o all 0 the next cycle.
REQ-032 Reset asserted mid-RUN aborts immediately, with no done_o pulse.

Structure
REQ-033 Package pulse_gen_pkg holds the FSM state enum and the defaults for N_CH and CNT_W.
REQ-034 Sub-module pulse_gen_ch holds the per-channel shadow high_cnt/enable, comparator and output register; it is instantiated N_CH times by generate.

Verification
REQ-035 Reset, then start with period=10, high_cnt={3,7}, continuous, src=2'b11 -> ch0 high 3 of every 10 cycles, ch1 high 7, first rising edge one cycle after start.
REQ-036 Burst mode, period=4, burst_len=3, high_cnt=2 -> exactly 3 pulses of 2 cycles; done_o high for 1 cycle, 12 cycles after RUN entry; busy_o low afterward.
REQ-037 Start with period=0, or burst mode with burst_len=0 -> cfg_err_o pulse, busy_o stays 0; start and stop together -> nothing happens.
REQ-038 Continuous run with period=8; stop_i asserted at phase 2 -> output completes that period, done_o at the wrap; high_cnt changed mid-period takes effect only at the next period.
REQ-039 Edge duties with period=5: high_cnt=0 -> constant low; high_cnt=5 and high_cnt=9 -> constant high; ch_en=0 or src=0 -> low.
REQ-040 wb_rst_i asserted at phase 3 of a burst -> all outputs 0 the next cycle, no done_o; a new start is then accepted normally.
